// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: write-back selects, load/store size codes,
// FSM states and the misalignment rule.
package mem_pkg;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DRAM  = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;
  localparam logic [1:0] WD_AUIPC = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  // f3[1:0] carries the access size for both loads and stores (00 byte, 01 half, 10 word).
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data RAM (slave).
// Handshake: dram_req is held with addr/we/be/wdata stable until the slave answers with a
// one-cycle dram_ack; dram_rdata is valid in the ack cycle only.
interface mem_stage_if;
  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [3:0]  dram_be;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;

  modport master (
    output dram_req, dram_we, dram_addr, dram_be, dram_wdata,
    input  dram_ack, dram_rdata
  );

  modport slave (
    input  dram_req, dram_we, dram_addr, dram_be, dram_wdata,
    output dram_ack, dram_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane selection: picks the addressed byte/halfword/word from the read word and
// sign- or zero-extends it according to f3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    unique case (f3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: data-memory access FSM, MEM/WB register and
// write-back select. Optional ack timeout with sticky mem_err under `MEM_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] mem_rd2,
  input  logic [31:0] mem_alu_c,
  input  logic [31:0] mem_auipc,
  input  logic [1:0]  mem_wd_sel,
  input  logic        mem_dram_we,
  input  logic        is_load_mem,
  input  logic        mem_rf_we,
  mem_stage_if.master dram,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic [31:0] wb_wd,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] inst_wb,
  output logic [31:0] pc_wb,
  output logic        is_load_wb,
  output logic        mem_err,
  output mem_state_e  dbg_state
);

  mem_state_e  state, state_n;
  logic [31:0] load_q, load_n, load_data, wd_next;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [3:0]  be_base;
  logic        memop, misal, start, in_access, timeout_hit;

  assign f3        = inst_mem[14:12];
  assign off       = mem_alu_c[1:0];
  assign memop     = is_load_mem | mem_dram_we;
  assign misal     = is_misaligned(f3, off);
  assign start     = (state == IDLE) && memop && !misal;
  assign in_access = (state == ACCESS);
  assign dbg_state = state;

  mem_load_align u_align (
    .rdata (dram.dram_rdata),
    .off   (off),
    .f3    (f3),
    .data  (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // An ack arriving in the final allowed cycle still wins over the abort.
  assign timeout_hit = in_access && !dram.dram_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= in_access ? wait_cnt + CNT_W'(1) : '0;
      if (timeout_hit) mem_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      state  <= state_n;
      load_q <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    load_n  = load_q;
    unique case (state)
      IDLE:   if (start) state_n = ACCESS;
      ACCESS: begin
        if (dram.dram_ack) begin
          state_n = DONE;
          load_n  = load_data;
        end else if (timeout_hit) begin
          state_n = DONE;
          load_n  = '0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_stall    = start || in_access;
  assign mem_misalign = (state == IDLE) && memop && misal;

  // Bus fields are driven only while a request is outstanding.
  always_comb begin
    be_base = 4'b1111;
    unique case (f3[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    dram.dram_req   = in_access;
    dram.dram_we    = in_access && mem_dram_we;
    dram.dram_addr  = in_access ? {mem_alu_c[31:2], 2'b00} : '0;
    dram.dram_be    = in_access ? (be_base << off) : '0;
    dram.dram_wdata = '0;
    if (in_access) begin
      unique case (f3[1:0])
        2'b00:   dram.dram_wdata = {4{mem_rd2[7:0]}};
        2'b01:   dram.dram_wdata = {2{mem_rd2[15:0]}};
        default: dram.dram_wdata = mem_rd2;
      endcase
    end
  end

  // Load data is only meaningful in DONE; misaligned or non-memory ops read as 0.
  always_comb begin
    wd_next = '0;
    unique case (mem_wd_sel)
      WD_ALU:   wd_next = mem_alu_c;
      WD_DRAM:  wd_next = (state == DONE) ? load_q : '0;
      WD_PC4:   wd_next = pc_mem + 32'd4;
      WD_AUIPC: wd_next = mem_auipc;
      default:  wd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || mem_stall) begin
      wb_wd      <= '0;
      wb_rf_we   <= 1'b0;
      wb_rd      <= '0;
      inst_wb    <= '0;
      pc_wb      <= '0;
      is_load_wb <= 1'b0;
    end else begin
      wb_wd      <= wd_next;
      wb_rf_we   <= mem_rf_we;
      wb_rd      <= inst_mem[11:7];
      inst_wb    <= inst_mem;
      pc_wb      <= pc_mem;
      is_load_wb <= is_load_mem;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized instruction
// stream scored against a specification-level model.
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_mem, pc_mem, mem_rd2, mem_alu_c, mem_auipc;
  logic [1:0]  mem_wd_sel;
  logic        mem_dram_we, is_load_mem, mem_rf_we;
  logic        mem_stall, mem_misalign, wb_rf_we, is_load_wb, mem_err;
  logic [31:0] wb_wd, inst_wb, pc_wb;
  logic [4:0]  wb_rd;
  mem_pkg::mem_state_e dbg_state;

  mem_stage_if dram ();

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        err_model = 1'b0;
  logic [31:0] exp_q[$];

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk), .rst_n (rst_n), .inst_mem (inst_mem), .pc_mem (pc_mem),
    .mem_rd2 (mem_rd2), .mem_alu_c (mem_alu_c), .mem_auipc (mem_auipc),
    .mem_wd_sel (mem_wd_sel), .mem_dram_we (mem_dram_we), .is_load_mem (is_load_mem),
    .mem_rf_we (mem_rf_we), .dram (dram), .mem_stall (mem_stall),
    .mem_misalign (mem_misalign), .wb_wd (wb_wd), .wb_rf_we (wb_rf_we), .wb_rd (wb_rd),
    .inst_wb (inst_wb), .pc_wb (pc_wb), .is_load_wb (is_load_wb), .mem_err (mem_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int unsigned idx, b, h;
    idx = addr % 4;
    b   = (rdata >> (8 * idx)) % 256;
    h   = (rdata >> (8 * idx)) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
    return {12'h0, 5'd2, f3, rd, opc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    inst_mem = '0; pc_mem = '0; mem_rd2 = '0; mem_alu_c = '0; mem_auipc = '0;
    mem_wd_sel = '0; mem_dram_we = 0; is_load_mem = 0; mem_rf_we = 0;
    dram.dram_ack = 0; dram.dram_rdata = '0;
  endtask

  // Present one instruction in MEM, play the RAM (ack after `delay` extra wait cycles,
  // never when delay < 0) and check bus, stall count and the resulting MEM/WB contents.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rd2,
                       input logic [31:0] alu, input logic [31:0] auipc, input logic [1:0] sel,
                       input logic we, input logic ld, input logic rfwe, input int delay,
                       input logic [31:0] rdata, input logic noise);
    int unsigned size, idx;
    int          stalls, reqs, mis_cnt, exp_reqs, exp_stalls;
    logic        memop, mis, amem, done, prev_stall, seen_we, timed_out;
    logic [3:0]  seen_be, exp_be;
    logic [31:0] seen_addr, seen_wdata, exp_wdata, exp_wd, got_wd;
    logic [2:0]  f3;
    f3 = inst[14:12];
    size = f3 % 4;
    idx = alu % 4;
    memop = ld | we;
    mis = memop && ((size == 1 && (idx % 2) != 0) || (size == 2 && idx != 0));
    amem = memop && !mis;
    timed_out = amem && (delay < 0);
    exp_reqs = amem ? ((delay < 0) ? TMO : delay + 1) : 0;
    exp_stalls = amem ? exp_reqs + 1 : 0;
    exp_be = (size == 0) ? 4'(1 << idx) : (size == 1) ? 4'(3 << idx) : 4'hF;
    exp_wdata = (size == 0) ? rd2[7:0] * 32'h0101_0101 :
                (size == 1) ? rd2[15:0] * 32'h0001_0001 : rd2;
    case (sel)
      2'd0: exp_wd = alu;
      2'd1: exp_wd = (ld && amem && !timed_out) ? ref_load(rdata, alu, f3) : 32'h0;
      2'd2: exp_wd = pc + 32'd4;
      default: exp_wd = auipc;
    endcase
    if (timed_out) err_model = 1'b1;
    exp_q.push_back(exp_wd);

    inst_mem = inst; pc_mem = pc; mem_rd2 = rd2; mem_alu_c = alu; mem_auipc = auipc;
    mem_wd_sel = sel; mem_dram_we = we; is_load_mem = ld; mem_rf_we = rfwe;
    stalls = 0; reqs = 0; mis_cnt = 0; done = 0; prev_stall = 0;
    seen_be = '0; seen_addr = '0; seen_wdata = '0; seen_we = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (wb_rf_we !== 1'b0 || inst_wb !== 32'h0) begin
          n_fail++;
          $display("FAIL bubble: wb_rf_we=%0b inst_wb=%h required 0/0", wb_rf_we, inst_wb);
        end
      end
      if (mem_misalign) mis_cnt++;
      dram.dram_ack = 0;
      dram.dram_rdata = $urandom;
      if (dram.dram_req) begin
        reqs++;
        seen_be = dram.dram_be; seen_addr = dram.dram_addr;
        seen_wdata = dram.dram_wdata; seen_we = dram.dram_we;
        if (delay >= 0 && reqs == delay + 1) begin
          dram.dram_ack = 1; dram.dram_rdata = rdata;
        end
      end else if (noise) begin
        dram.dram_ack = 1;
      end
      prev_stall = mem_stall;
      if (mem_stall) stalls++; else done = 1;
      @(posedge clk); #1;
      dram.dram_ack = 0;
    end

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL completion: instruction %h still stalled after 64 cycles", inst);
    end
    n_checks++;
    if (stalls !== exp_stalls) begin
      n_fail++;
      $display("FAIL stall_cycles: inst %h got %0d required %0d", inst, stalls, exp_stalls);
    end
    n_checks++;
    if (reqs !== exp_reqs) begin
      n_fail++;
      $display("FAIL req_cycles: inst %h got %0d required %0d", inst, reqs, exp_reqs);
    end
    n_checks++;
    if (mis_cnt !== (mis ? 1 : 0)) begin
      n_fail++;
      $display("FAIL misalign_pulse: inst %h got %0d required %0d", inst, mis_cnt, mis ? 1 : 0);
    end
    if (amem) begin
      n_checks++;
      if (seen_addr !== alu - idx || seen_be !== exp_be || seen_we !== we) begin
        n_fail++;
        $display("FAIL bus: addr=%h be=%b we=%0b required addr=%h be=%b we=%0b",
                 seen_addr, seen_be, seen_we, alu - idx, exp_be, we);
      end
      if (we) begin
        n_checks++;
        if (seen_wdata !== exp_wdata) begin
          n_fail++;
          $display("FAIL wdata: got %h required %h", seen_wdata, exp_wdata);
        end
      end
    end
    // Scoreboard: wb_wd against the queued expectation.
    got_wd = exp_q.pop_front();
    n_checks++;
    if (wb_wd !== got_wd) begin
      n_fail++;
      $display("FAIL wb_wd: inst %h got %h required %h", inst, wb_wd, got_wd);
    end
    n_checks++;
    if (wb_rf_we !== rfwe || wb_rd !== inst[11:7] || inst_wb !== inst || pc_wb !== pc ||
        is_load_wb !== ld) begin
      n_fail++;
      $display("FAIL wb_fields: rf_we=%0b rd=%0d inst=%h pc=%h ld=%0b required %0b %0d %h %h %0b",
               wb_rf_we, wb_rd, inst_wb, pc_wb, is_load_wb, rfwe, inst[11:7], inst, pc, ld);
    end
    n_checks++;
    if (mem_err !== err_model) begin
      n_fail++;
      $display("FAIL mem_err: got %0b required %0b", mem_err, err_model);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    err_model = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dram.dram_req, dram.dram_we, mem_stall, mem_misalign, wb_rf_we, is_load_wb, mem_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%0b we=%0b stall=%0b mis=%0b rf_we=%0b ld=%0b err=%0b required all 0",
               dram.dram_req, dram.dram_we, mem_stall, mem_misalign, wb_rf_we, is_load_wb, mem_err);
    end
    n_checks++;
    if (dram.dram_addr !== 32'h0 || dram.dram_be !== 4'h0 || dram.dram_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h be=%b wdata=%h required 0", dram.dram_addr, dram.dram_be,
               dram.dram_wdata);
    end
    n_checks++;
    if (wb_wd !== 32'h0 || inst_wb !== 32'h0 || pc_wb !== 32'h0 || wb_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_wb: wd=%h inst=%h pc=%h rd=%0d required 0", wb_wd, inst_wb, pc_wb, wb_rd);
    end
    n_checks++;
    if (dbg_state !== mem_pkg::IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required IDLE", dbg_state);
    end
    rst_n = 1;
  endtask

  task automatic test_nonmem();
    // add x1,x2,x3 with the ALU result selected
    issue(32'h0031_00B3, 32'h0000_0100, 32'h0, 32'h0000_1234, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 0);
    // jal-style link value wrapping past 2^32
    issue(32'h0000_00EF, 32'hFFFF_FFFC, 32'h0, 32'h5555_5555, 32'h0, 2'd2, 0, 0, 1, 0, 32'h0, 0);
    // auipc result selected
    issue(32'h0000_1197, 32'h0000_2000, 32'h0, 32'h0, 32'h0000_3000, 2'd3, 0, 0, 1, 0, 32'h0, 0);
  endtask

  task automatic test_load_byte();
    issue(mk_inst(3'd0, 5'd5, 7'h03), 32'h104, 32'h0, 32'h0000_1003, 32'h0, 2'd1, 0, 1, 1, 2,
          32'h80FF_FFFF, 0);
    issue(mk_inst(3'd4, 5'd6, 7'h03), 32'h108, 32'h0, 32'h0000_1003, 32'h0, 2'd1, 0, 1, 1, 2,
          32'h80FF_FFFF, 1);
  endtask

  task automatic test_store_half();
    issue(mk_inst(3'd1, 5'd0, 7'h23), 32'h10C, 32'h0000_BEEF, 32'h0000_2002, 32'h0, 2'd0, 1, 0, 0,
          0, 32'h0, 0);
  endtask

  task automatic test_misaligned();
    issue(mk_inst(3'd2, 5'd7, 7'h03), 32'h110, 32'h0, 32'h0000_3001, 32'h0, 2'd1, 0, 1, 1, 0,
          32'hDEAD_BEEF, 0);
    issue(mk_inst(3'd1, 5'd0, 7'h23), 32'h114, 32'h1234_5678, 32'h0000_3003, 32'h0, 2'd0, 1, 0, 0,
          0, 32'h0, 0);
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    issue(mk_inst(3'd2, 5'd8, 7'h03), 32'h118, 32'h0, 32'h0000_0100, 32'h0, 2'd1, 0, 1, 1, -1,
          32'h0, 0);
    issue(32'h0031_00B3, 32'h11C, 32'h0, 32'h0000_0042, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 0);
`endif
  endtask

  task automatic test_reset_mid_access();
    inst_mem = mk_inst(3'd2, 5'd9, 7'h03); pc_mem = 32'h120; mem_alu_c = 32'h0000_0040;
    mem_wd_sel = 2'd1; is_load_mem = 1; mem_dram_we = 0; mem_rf_we = 1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dram.dram_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req_up: got %0b required 1", dram.dram_req);
    end
    rst_n = 0;
    clear_inputs();
    @(posedge clk); #1;
    err_model = 0;
    n_checks++;
    if (dram.dram_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%0b stall=%0b required 0/0", dram.dram_req, mem_stall);
    end
    n_checks++;
    if ({wb_wd, wb_rf_we, wb_rd, inst_wb, pc_wb, is_load_wb} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_wb: wd=%h rf_we=%0b rd=%0d inst=%h pc=%h ld=%0b required 0",
               wb_wd, wb_rf_we, wb_rd, inst_wb, pc_wb, is_load_wb);
    end
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] addr;
    int          kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      case (kind)
        0: issue(32'h0031_00B3 | ($urandom_range(1, 31) << 7), $urandom, $urandom, $urandom,
                 $urandom, 2'($urandom_range(0, 3) == 1 ? 0 : $urandom_range(0, 3)), 0, 0,
                 1'($urandom_range(0, 1)), 0, 32'h0, 1'($urandom_range(0, 1)));
        1: issue(mk_inst(ld_f3[$urandom_range(0, 4)], 5'($urandom_range(1, 31)), 7'h03),
                 $urandom, $urandom, addr, $urandom, 2'd1, 0, 1, 1, $urandom_range(0, 3),
                 $urandom, 1'($urandom_range(0, 1)));
        default: issue(mk_inst(3'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), 7'h23),
                 $urandom, $urandom, addr, $urandom, 2'd0, 1, 0, 0, $urandom_range(0, 3),
                 32'h0, 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer of the EX/MEM pipeline register: runs the MEM stage of the 5-stage RV32I pipeline.
- Issues data-memory accesses over a req/ack bus, stalls the pipeline until each access completes, and selects the write-back data.
- Contains the MEM/WB pipeline register that feeds the WB stage and the forwarding logic.

Parameters:
- TIMEOUT_CYCLES, 16: ack wait limit. Only used when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- inst_mem  in  32  instruction in MEM
- pc_mem  in  32  its PC
- mem_rd2  in  32  store data
- mem_alu_c  in  32  ALU result / address
- mem_auipc  in  32  auipc result
- mem_wd_sel  in  2  write-back select
- mem_dram_we  in  1  store
- is_load_mem  in  1  load
- mem_rf_we  in  1  register write enable
- dram_req  out  1  access request
- dram_we  out  1  write strobe
- dram_addr  out  32  word-aligned address
- dram_be  out  4  byte enables
- dram_wdata  out  32  lane-aligned store data
- dram_ack  in  1  access complete
- dram_rdata  in  32  read word
- mem_stall  out  1  freeze IF..EX/MEM
- mem_misalign  out  1  one-cycle pulse, misaligned access dropped
- wb_wd  out  32  write-back data
- wb_rf_we  out  1  write enable
- wb_rd  out  5  destination register
- inst_wb  out  32  instruction in WB
- pc_wb  out  32  its PC
- is_load_wb  out  1  load in WB
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only)

Behaviour:
- Reset: clk and rst_n only. Synchronous, active-low, sampled on the rising clk edge. All registers clear to 0 and state goes to IDLE. All outputs are 0 after reset.
- Memory op: memop = is_load_mem | mem_dram_we. Size/sign come from f3 = inst_mem[14:12]:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No request is issued and no stall is raised.
  - mem_misalign pulses for 1 cycle.
  - A load returns 0; a store is discarded.
- Alignment:
  - dram_addr = {mem_alu_c[31:2],2'b00}.
  - dram_be = 0001/0011/1111 shifted left by addr[1:0].
  - dram_wdata = mem_rd2 replicated per lane.
  - Load data = the selected lane, sign- or zero-extended per f3.
- FSM states:
  - IDLE: aligned memop → ACCESS, mem_stall=1.
  - ACCESS: dram_req=1, dram_we=mem_dram_we, mem_stall=1. dram_ack → capture aligned load data → DONE.
  - DONE: mem_stall=0 → IDLE.
- Outputs: dram_req and dram_we are decoded from registered state only. mem_stall = (IDLE & aligned memop) | ACCESS.
- Latency: minimum 2 stall cycles (ack in the first ACCESS cycle); each extra ack-wait cycle adds one. dram_ack is ignored outside ACCESS.
- Input stability: EX/MEM inputs are held stable by the upstream freeze while mem_stall=1. The block relies on this.
- MEM/WB register, each rising edge:
  - If mem_stall=1: capture a bubble (wb_rf_we=0, inst_wb=0, is_load_wb=0; other fields 0).
  - Otherwise: capture wb_rd=inst_mem[11:7], inst_mem, pc_mem, is_load_mem, and wb_rf_we=mem_rf_we.
- wb_wd select: mem_wd_sel 00 = mem_alu_c, 01 = load data, 10 = pc_mem+4 (32-bit wrap), 11 = mem_auipc.
- Back-to-back memops: after DONE the next instruction starts a new IDLE→ACCESS sequence. There is no overlap.
- Reset mid-access: dram_req drops after the reset edge and the pending access is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. After TIMEOUT_CYCLES cycles with no ack:
  - the access is aborted and the FSM goes to DONE;
  - load data = 0;
  - mem_err is set and stays 1 until reset.
- Undefined: no counter exists, the wait is unbounded, and mem_err is tied to 0.

Decomposition:
- Shared package mem_pkg holds:
  - wd_sel encodings: WD_ALU, WD_DRAM, WD_PC4, WD_AUIPC.
  - f3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, ACCESS, DONE.
- One sub-module, mem_load_align: combinational lane select and extension (rdata, addr[1:0], f3 → 32-bit data).

Test Plan:
- Non-memory op (ADD, wd_sel=00, alu_c=0x1234, rf_we=1) → no stall; next cycle wb_wd=0x1234, wb_rf_we=1.
- LB at 0x1003, rdata=0x80FF_FF_FF, ack after 3 cycles → dram_be=1000, 4 stall cycles; then wb_wd=0xFFFFFF80. The same access with LBU gives 0x00000080.
- SH at 0x2002, rd2=0x0000BEEF, immediate ack → dram_we=1, dram_be=1100, dram_wdata=0xBEEFBEEF, 2 stall cycles, wb_rf_we=0.
- LW at 0x3001 → no dram_req, mem_misalign pulses, no stall, wb_wd=0.
- rst_n low during ACCESS → next cycle dram_req=0, mem_stall=0, all wb_* outputs = 0.
- (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) LW with no ack → abort after 4 ACCESS cycles, wb_wd=0, mem_err=1 held until reset.
